div_unit: RTL

Iterative 32-bit integer divider for the MIPS datapath, executing DIV and DIVU. It is the inverse companion of the combinational add/subtract arithmetic unit, implemented as one restoring subtract-and-shift step per clock. It takes a start pulse from the control unit, holds `busy` while iterating, and produces the quotient (LO) and remainder (HI) with a one-cycle `done` pulse.

---
 rtl/mips_pkg.sv | 13 +
 rtl/div_step.sv | 31 +++
 rtl/div_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: word width and the divider's state encoding.
package mips_pkg;

  localparam int WORD_W    = 32;
  localparam int DIV_STEPS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_STEPS);

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;
  localparam logic [1:0] DIV_DONE = 2'd3;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit, try to subtract
// the divisor, and keep the difference only when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The shifted remainder keeps its top bit: with divisors at or above 2^(WIDTH-1)
  // the partial remainder can have its MSB set, so the subtract is WIDTH+1 bits.
  assign shifted = {rem, next_bit};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path, or a latch is inferred.
    rem_next = shifted[WIDTH-1:0];
    q_bit    = 1'b0;
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      q_bit    = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit: one restoring step per clock on operand magnitudes,
// then a sign fix-up cycle that registers quotient (LO) and remainder (HI).
module div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic [1:0]           state;
  logic [DIV_CNT_W-1:0] count;
  logic [WIDTH-1:0]     dq;       // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     div_mag;
  logic                 neg_q;
  logic                 neg_r;
  logic                 dz;

  logic [WIDTH-1:0]     rem_next;
  logic                 q_bit;
  logic                 dd_neg;
  logic                 dv_neg;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .next_bit (dq[WIDTH-1]),
    .divisor  (div_mag),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign dd_neg = is_signed & dividend[WIDTH-1];
  assign dv_neg = is_signed & divisor[WIDTH-1];

  assign busy = (state == DIV_CALC) || (state == DIV_FIX);
  assign done = (state == DIV_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state       <= DIV_IDLE;
      count       <= '0;
      dq          <= '0;
      rem         <= '0;
      div_mag     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              // Divide-by-zero skips the iteration; FIX publishes the raw dividend as HI.
              dz    <= 1'b1;
              dq    <= dividend;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= DIV_FIX;
            end else begin
              dz      <= 1'b0;
              dq      <= dd_neg ? -dividend : dividend;
              div_mag <= dv_neg ? -divisor : divisor;
              neg_q   <= dd_neg ^ dv_neg;
              neg_r   <= dd_neg;
              rem     <= '0;
              count   <= DIV_CNT_W'(DIV_STEPS - 1);
              state   <= DIV_CALC;
            end
          end
        end

        DIV_CALC: begin
          rem   <= rem_next;
          dq    <= {dq[WIDTH-2:0], q_bit};
          count <= count - DIV_CNT_W'(1);
          if (count == '0) begin
            state <= DIV_FIX;
          end
        end

        DIV_FIX: begin
          if (dz) begin
            quotient    <= '1;
            remainder   <= dq;
            div_by_zero <= 1'b1;
          end else begin
            // Negating the 0x80000000 magnitude wraps back to itself, which is the required result.
            quotient    <= neg_q ? -dq : dq;
            remainder   <= neg_r ? -rem : rem;
            div_by_zero <= 1'b0;
          end
          state <= DIV_DONE;
        end

        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule
